// File: rtl/d_mem_pkg.sv
// Shared types and helpers for the sized data memory: access-size encoding,
// byte-enable generation, alignment check and load extraction/extension.
package d_mem_pkg;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int DATA_W    = NUM_LANES * VEC_W;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Context captured with a load; it shapes the response one cycle later.
  typedef struct packed {
    size_e      size;
    logic       is_unsigned;
    logic [1:0] lane;
  } ld_ctx_t;

  function automatic logic [NUM_LANES-1:0] byte_en(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic is_aligned(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~lane[0];
      SZ_WORD: is_aligned = (lane == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(logic [DATA_W-1:0] word, ld_ctx_t ctx);
    logic [DATA_W-1:0] sh;
    logic              sb;
    sh = word >> {ctx.lane, 3'b000};
    sb = 1'b0;
    case (ctx.size)
      SZ_BYTE: begin
        sb = ~ctx.is_unsigned & sh[7];
        load_extend = {{(DATA_W-8){sb}}, sh[7:0]};
      end
      SZ_HALF: begin
        sb = ~ctx.is_unsigned & sh[15];
        load_extend = {{(DATA_W-16){sb}}, sh[15:0]};
      end
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/d_mem_lane_align.sv
// Combinational lane alignment: replicates store data onto the addressed byte
// lanes with their enables, and pulls a load field down to bit 0.
module d_mem_lane_align
  import d_mem_pkg::*;
(
  input  size_e                            size,
  input  logic [1:0]                       lane,
  input  logic [DATA_W-1:0]                wdata,
  output logic [NUM_LANES-1:0]             be,
  output logic [NUM_LANES-1:0][VEC_W-1:0]  wdata_rep,
  input  logic [DATA_W-1:0]                rword,
  input  ld_ctx_t                          ctx,
  output logic [DATA_W-1:0]                rdata
);

  logic [NUM_LANES-1:0][VEC_W-1:0] wd;

  assign wd = wdata;
  assign be = byte_en(size, lane);

  // Byte stores fan byte 0 to every lane, halves fan the low pair to both pairs.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdata_rep[i] = (size == SZ_BYTE) ? wd[0] :
                          (size == SZ_HALF) ? wd[i % 2] : wd[i];
  end

  assign rdata = load_extend(rword, ctx);

endmodule

// File: rtl/d_mem_sized.sv
// Byte-addressed data memory with byte/half/word access, 1-cycle read latency,
// and a registered error pulse for illegal requests.
// Optional: define D_MEM_BOUNDS_CHECK_EN to reject addresses beyond the array
// instead of wrapping them.
module d_mem_sized
  import d_mem_pkg::*;
#(
  parameter int MEM_WORDS  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  err
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int STAGES = 1;

  logic [NUM_LANES-1:0][VEC_W-1:0] mem [MEM_WORDS];

  size_e                           sz;
  logic [1:0]                      lane;
  logic [IDX_W-1:0]                idx;
  logic [ADDR_WIDTH-1:0]           addr_hi;
  logic                            in_range;
  logic                            legal;
  logic                            acc_st, acc_ld, acc_bad;
  logic [NUM_LANES-1:0]            be;
  logic [NUM_LANES-1:0][VEC_W-1:0] wdata_rep;
  logic [DATA_W-1:0]               rword_q;
  ld_ctx_t                         ctx_q;
  logic [STAGES:1]                 vld_pipe, err_pipe;

  assign sz      = size_e'(size);
  assign lane    = addr[1:0];
  assign idx     = addr[IDX_W+1:2];
  assign addr_hi = addr >> (IDX_W + 2);

`ifdef D_MEM_BOUNDS_CHECK_EN
  assign in_range = (addr_hi == '0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |addr_hi;
  assign in_range       = 1'b1;
`endif

  assign legal   = is_aligned(sz, lane) & in_range;
  assign acc_st  = req &  we & legal;
  assign acc_ld  = req & ~we & legal;
  assign acc_bad = req & ~legal;

  d_mem_lane_align u_align (
    .size      (sz),
    .lane      (lane),
    .wdata     (wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rword     (rword_q),
    .ctx       (ctx_q),
    .rdata     (rdata)
  );

  // Array is not reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (acc_st) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (be[b]) mem[idx][b] <= wdata_rep[b];
      end
    end
  end

  // rdata is derived from these, so it holds until the next legal load lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rword_q <= '0;
      ctx_q   <= '0;
    end else if (acc_ld) begin
      rword_q <= mem[idx];
      ctx_q   <= '{size: sz, is_unsigned: is_unsigned, lane: lane};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe <= STAGES'({vld_pipe, acc_ld});
      err_pipe <= STAGES'({err_pipe, acc_bad});
    end
  end

  assign rvalid = vld_pipe[STAGES];
  assign err    = err_pipe[STAGES];

endmodule

// File: tb/tb_d_mem_sized.sv
// Directed self-checking bench for d_mem_sized.
module tb_d_mem_sized;

  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        is_unsigned = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  int ntests = 0;
  int nfail  = 0;

  d_mem_sized #(.MEM_WORDS(MEM_WORDS), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .size        (size),
    .is_unsigned (is_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for one cycle; outputs reflect it on return.
  task automatic cyc(input logic r, input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; size = s; is_unsigned = u; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdata",  rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_err",    {31'b0, err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    cyc(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    chk("st_word_rvalid", {31'b0, rvalid}, 32'h0);
    chk("st_word_err",    {31'b0, err}, 32'h0);

    // Load accepted, then reset lands while the response is being presented.
    req = 1'b1; we = 1'b0; size = 2'b10; is_unsigned = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    chk("pre_rst_rvalid", {31'b0, rvalid}, 32'h1);
    chk("pre_rst_rdata",  rdata, 32'hDEADBEEF);
    rst_n = 1'b0; req = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("mid_rst_rdata",  rdata, 32'h0);
    chk("mid_rst_err",    {31'b0, err}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("post_rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("post_rst_rdata",  rdata, 32'h0);

    cyc(1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("ld_word_rvalid", {31'b0, rvalid}, 32'h1);
    chk("ld_word_rdata",  rdata, 32'hDEADBEEF);
    cyc(0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("rvalid_pulse", {31'b0, rvalid}, 32'h0);
    chk("idle_hold",    rdata, 32'hDEADBEEF);

    cyc(1, 1, 2'b00, 0, 32'h13, 32'h12345680);
    chk("st_byte_rvalid", {31'b0, rvalid}, 32'h0);
    cyc(1, 0, 2'b00, 0, 32'h13, 32'h0);
    chk("ld_sbyte", rdata, 32'hFFFFFF80);
    cyc(1, 0, 2'b00, 1, 32'h13, 32'h0);
    chk("ld_ubyte", rdata, 32'h00000080);
    cyc(1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("ld_word_after_byte", rdata, 32'h80ADBEEF);

    cyc(1, 1, 2'b01, 0, 32'h11, 32'h00001234);
    chk("mis_half_err",    {31'b0, err}, 32'h1);
    chk("mis_half_rvalid", {31'b0, rvalid}, 32'h0);
    chk("mis_half_hold",   rdata, 32'h80ADBEEF);
    cyc(1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("mis_half_errclr", {31'b0, err}, 32'h0);
    chk("mis_half_mem",    rdata, 32'h80ADBEEF);

    cyc(1, 1, 2'b11, 0, 32'h10, 32'h00001234);
    chk("rsvd_err",    {31'b0, err}, 32'h1);
    chk("rsvd_rvalid", {31'b0, rvalid}, 32'h0);
    cyc(1, 0, 2'b10, 0, 32'h10, 32'h0);
    chk("rsvd_mem",    rdata, 32'h80ADBEEF);

    cyc(1, 0, 2'b10, 0, 32'h12, 32'h0);
    chk("mis_ld_err",    {31'b0, err}, 32'h1);
    chk("mis_ld_rvalid", {31'b0, rvalid}, 32'h0);
    chk("mis_ld_hold",   rdata, 32'h80ADBEEF);

    cyc(1, 1, 2'b10, 0, 32'h20, 32'hA5A5A5A5);
    cyc(1, 0, 2'b10, 0, 32'h20, 32'h0);
    chk("b2b_rvalid", {31'b0, rvalid}, 32'h1);
    chk("b2b_rdata",  rdata, 32'hA5A5A5A5);

    cyc(1, 1, 2'b01, 0, 32'h22, 32'h0000BEEF);
    cyc(1, 0, 2'b01, 0, 32'h22, 32'h0);
    chk("ld_shalf_hi", rdata, 32'hFFFFBEEF);
    cyc(1, 0, 2'b01, 1, 32'h22, 32'h0);
    chk("ld_uhalf_hi", rdata, 32'h0000BEEF);
    cyc(1, 0, 2'b01, 0, 32'h20, 32'h0);
    chk("ld_shalf_lo", rdata, 32'hFFFFA5A5);
    cyc(1, 0, 2'b00, 1, 32'h21, 32'h0);
    chk("ld_ubyte_l1", rdata, 32'h000000A5);
    cyc(1, 0, 2'b10, 0, 32'h20, 32'h0);
    chk("half_st_word", rdata, 32'hBEEFA5A5);

    cyc(1, 1, 2'b10, 0, 32'h4, 32'h00000001);
    cyc(1, 0, 2'b10, 0, 32'(MEM_WORDS * 4 + 4), 32'h0);
`ifdef D_MEM_BOUNDS_CHECK_EN
    chk("oob_err",    {31'b0, err}, 32'h1);
    chk("oob_rvalid", {31'b0, rvalid}, 32'h0);
    chk("oob_hold",   rdata, 32'hBEEFA5A5);
`else
    chk("wrap_err",    {31'b0, err}, 32'h0);
    chk("wrap_rvalid", {31'b0, rvalid}, 32'h1);
    chk("wrap_rdata",  rdata, 32'h00000001);
`endif

    cyc(0, 1, 2'b10, 0, 32'h20, 32'h11111111);
    chk("idle_rvalid", {31'b0, rvalid}, 32'h0);
    chk("idle_err",    {31'b0, err}, 32'h0);
    cyc(1, 0, 2'b10, 0, 32'h20, 32'h0);
    chk("idle_no_write", rdata, 32'hBEEFA5A5);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/d_mem_sized.md
Name: d_mem_sized

Overview:
- Byte-addressed, parametrised data memory. It is the next-generation store for the single-cycle/multicycle datapath.
- Supports byte, half and word loads and stores, using per-byte write enables and sign or zero extension on loads.
- Reads are synchronous with 1-cycle latency and an rvalid strobe. Misaligned accesses raise a registered error flag instead of corrupting memory.
- Sits between the ALU address output and the writeback mux.

Parameters:
- MEM_WORDS, 64, number of 32-bit words stored (power of two, >= 2)
- ADDR_WIDTH, 32, width of the byte address input
- IDX_W, $clog2(MEM_WORDS), derived word-index width (localparam, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request this cycle
- we  in  1  1 = store, 0 = load (sampled only when req=1)
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- is_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend
- addr  in  ADDR_WIDTH  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rdata  out  32  load result, valid when rvalid=1, held until the next load completes
- rvalid  out  1  1-cycle pulse, one cycle after an accepted legal load
- err  out  1  1-cycle pulse, one cycle after an illegal request

Behaviour:
- Reset (async assert, sync deassert at the reset flop input is the integrator's concern): rdata=0, rvalid=0, err=0, internal load-tracking regs=0. Array contents are not reset.
- Word index = addr[IDX_W+1:2]. Byte lane = addr[1:0].
- Legality: size=11 is illegal. Half with addr[0]=1 is illegal. Word with addr[1:0]!=0 is illegal.
- Legal store, cycle N: byte-enable mask from size and lane; wdata replicated to the lane; only enabled bytes are written at edge N. rvalid stays 0.
- Legal load, cycle N: word read at edge N; lane, size and is_unsigned captured. At cycle N+1: rvalid=1 and rdata = extracted field shifted to bit 0, extended per is_unsigned.
- Illegal request, cycle N: no write, no read, rdata unchanged. err=1 in cycle N+1, rvalid=0.
- Back-to-back: one request accepted every cycle; there is no ready signal and no stall.
- Load at N+1 to an address stored at N returns the stored data (array already updated).
- A load and a store cannot be simultaneous: a single req/we decides the access.
- req=0: rvalid=0, err=0, rdata holds.
- Address bits above IDX_W+1 are ignored (modulo wrap) unless the optional feature is enabled.
- Reset asserted mid-load: pending rvalid is cancelled and rdata returns to 0. A store already clocked in stays in the array.

Optional Feature:
- Macro: D_MEM_BOUNDS_CHECK_EN.
- Defined: any address with a nonzero bit above IDX_W+1 is illegal. It behaves as a misaligned access: no write, err pulse, no rvalid.
- Undefined: upper bits are ignored and accesses wrap modulo MEM_WORDS*4 bytes.

Decomposition:
- Package d_mem_pkg holds:
  - the size enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11;
  - the function that computes the byte-enable mask from size and lane;
  - the load-extract/extend function.
- Sub-module d_mem_lane_align: combinational store-replication and load-extraction logic, shared with the future instruction memory. The array and the response registers stay in the top module.

Test Plan:
- Reset with rst_n=0 mid-load, then release: rdata=0, rvalid=0, err=0; no stale rvalid after release.
- Store word 0xDEADBEEF at addr 0x10, then load word at 0x10: next cycle rvalid=1, rdata=0xDEADBEEF.
- Store byte 0x80 at addr 0x13:
  - signed byte load at 0x13 returns 0xFFFFFF80;
  - unsigned byte load returns 0x00000080;
  - word load at 0x10 returns 0x80ADBEEF.
- Half store 0x1234 at addr 0x11: err=1 next cycle, rvalid=0, a word load at 0x10 is unchanged. Repeat with size=11: same result.
- Back-to-back: store word 0xA5A5A5A5 at 0x20 in cycle N, load at 0x20 in N+1: rvalid in N+2 with 0xA5A5A5A5.
- Address (MEM_WORDS*4)+0x4, word load after storing 0x1 at 0x4: without the macro returns 0x00000001; with D_MEM_BOUNDS_CHECK_EN, err=1 and rvalid=0.
